// File: rtl/sr_pulse_arbiter.sv
// Round-robin arbiter driving set/reset pulses into an SR latch bank.
// Each accepted request pulses one latch, lets it settle, then reports q.
module sr_pulse_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_LATCH     = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int IDX_W         = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_set_i,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_LATCH-1:0]     s_o,
    output logic [NUM_LATCH-1:0]     r_o,
    input  logic [NUM_LATCH-1:0]     q_i,
    output logic                     rsp_valid_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W:0] NL = (IDX_W + 1)'(NUM_LATCH);

    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, RESP} state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] last_q, id_q;
    logic set_q, err_q, err_d;
    logic [IDX_W-1:0] idx_q;
    logic [NUM_LATCH-1:0] s_q, s_d, r_q, r_d;

    logic [NUM_REQ-1:0] gnt_vec;
    logic [ID_W-1:0] gnt_id;
    logic gnt_set, found, xfer, in_range;
    logic [IDX_W-1:0] gnt_idx;
    logic [NUM_LATCH-1:0] onehot;
    int sel;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        gnt_vec = '0;
        gnt_id  = '0;
        gnt_set = 1'b0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = (int'(last_q) + 1 + k) % NUM_REQ;
            if (!found && req_valid_i[sel]) begin
                found        = 1'b1;
                gnt_vec[sel] = 1'b1;
                gnt_id       = ID_W'(sel);
                gnt_set      = req_set_i[sel];
                gnt_idx      = req_idx_i[sel*IDX_W +: IDX_W];
            end
        end
    end

    assign req_ready_o = (state_q == IDLE) ? gnt_vec : '0;
    assign xfer        = (state_q == IDLE) && found;
    assign in_range    = {1'b0, gnt_idx} < NL;
    assign onehot      = NUM_LATCH'(1) << gnt_idx;

    // Next-state, pulse shaping and q sampling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        r_d     = r_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (in_range) begin
                        state_d = PULSE;
                        s_d     = gnt_set ? onehot : '0;
                        r_d     = gnt_set ? '0 : onehot;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == P_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    s_d     = '0;
                    r_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == S_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    err_d   = q_i[idx_q] != set_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pulse outputs and captured request
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            set_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            err_q   <= err_d;
            if (xfer) begin
                last_q <= gnt_id;
                id_q   <= gnt_id;
                set_q  <= gnt_set;
                idx_q  <= gnt_idx;
            end
        end
    end

    assign s_o         = s_q;
    assign r_o         = r_q;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_id_o    = rsp_valid_o ? id_q : '0;
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign busy_o      = state_q != IDLE;

endmodule

// File: tb/tb_sr_pulse_arbiter.sv
// Bench for sr_pulse_arbiter: reference timeline model plus response scoreboard.
// Uses a 6-latch bank so out-of-range indices can be exercised.
module tb_sr_pulse_arbiter;

    localparam int NR = 4;
    localparam int NL = 6;
    localparam int IW = 3;
    localparam int P  = 2;
    localparam int S  = 1;

    logic clk, arst_ni;
    logic [NR-1:0] req_valid, req_set, req_ready_o;
    logic [NR*IW-1:0] req_idx;
    logic [NL-1:0] s_o, r_o, q_i, q_bank, stuck0, stuck1;
    logic rsp_valid_o, rsp_err_o, busy_o;
    logic [1:0] rsp_id_o;

    int n_chk, n_fail, cyc;

    typedef struct {
        int id;
        bit err;
        int due;
    } rsp_t;
    rsp_t sb[$];

    sr_pulse_arbiter #(
        .NUM_REQ(NR), .NUM_LATCH(NL), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
    ) dut (
        .clk_i(clk), .arst_ni(arst_ni),
        .req_valid_i(req_valid), .req_set_i(req_set), .req_idx_i(req_idx),
        .req_ready_o(req_ready_o), .s_o(s_o), .r_o(r_o), .q_i(q_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial q_bank = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) q_bank <= (q_bank | s_o) & ~r_o;
    assign q_i = (q_bank | stuck1) & ~stuck0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: one operation at a time on a cycle timeline
    bit have_op, op_set, op_oor;
    int op_acc, op_resp, op_idx, ptr;
    logic [NR-1:0] exp_rdy;
    logic [NL-1:0] exp_s, exp_r, one;

    initial begin
        have_op = 0;
        ptr = NR - 1;
        forever begin
            @(negedge clk);
            if (!arst_ni) begin
                have_op = 0;
                ptr = NR - 1;
                sb.delete();
                chk("rst_s", s_o, 0);
                chk("rst_r", r_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_id_o}, 0);
            end else begin
                automatic int gid = 0;
                if (have_op && cyc > op_resp) have_op = 0;
                exp_rdy = '0;
                if (!have_op) begin
                    for (int k = 0; k < NR; k++) begin
                        automatic int j = (ptr + 1 + k) % NR;
                        if (exp_rdy == 0 && req_valid[j]) begin
                            exp_rdy[j] = 1'b1;
                            gid = j;
                        end
                    end
                end
                chk("ready", req_ready_o, exp_rdy);
                chk("busy", busy_o, have_op);
                exp_s = '0;
                exp_r = '0;
                one = 1;
                if (have_op && !op_oor && cyc > op_acc && cyc <= op_acc + P) begin
                    if (op_set) exp_s = one << op_idx;
                    else exp_r = one << op_idx;
                end
                chk("s_o", s_o, exp_s);
                chk("r_o", r_o, exp_r);
                chk("s_and_r", s_o & r_o, 0);
                chk("one_pulse", $countones(s_o | r_o) <= 1, 1);
                if (!rsp_valid_o) chk("rsp_idle", {rsp_err_o, rsp_id_o}, 0);
                if (exp_rdy != 0) begin
                    automatic rsp_t e;
                    have_op = 1;
                    ptr     = gid;
                    op_acc  = cyc;
                    op_set  = req_set[gid];
                    op_idx  = int'(req_idx[gid*IW +: IW]);
                    op_oor  = op_idx >= NL;
                    op_resp = op_acc + (op_oor ? 1 : P + S + 1);
                    e.id  = gid;
                    e.due = op_resp;
                    e.err = op_oor ? 1'b1 : (op_set ? stuck0[op_idx] : stuck1[op_idx]);
                    sb.push_back(e);
                end
            end
        end
    end

    // Monitor: every response must match the oldest outstanding transfer
    initial forever begin
        @(negedge clk);
        if (arst_ni) begin
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    automatic rsp_t e = sb.pop_front();
                    chk("rsp_id", rsp_id_o, e.id);
                    chk("rsp_err", rsp_err_o, e.err);
                    chk("rsp_time", cyc, e.due);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                automatic rsp_t e = sb.pop_front();
                chk("rsp_timeout", 0, e.id + 1);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (!busy_o) ok = 1;
        end
        chk("idle_wait", ok, 1);
    endtask

    task automatic run_one(input int id, input bit set, input int idx, input int exp_p);
        bit got = 0;
        int np = 0;
        int nr = 0;
        wait_idle();
        @(posedge clk);
        #1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_set[id] = set;
        req_idx[id*IW +: IW] = IW'(idx);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready_o[id]) got = 1;
        end
        chk("accept", got, 1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (8) begin
            @(negedge clk);
            np += $countones(s_o | r_o);
            nr += int'(rsp_valid_o);
        end
        chk("pulse_cnt", np, exp_p);
        chk("rsp_cnt", nr, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[$];
        int gcyc[$];
        bit got;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        stuck0 = '0;
        stuck1 = '0;
        arst_ni = 1'b0;
        req_valid = 4'hF;
        req_set = 4'b0101;
        req_idx = {3'd4, 3'd2, 3'd1, 3'd0};
        repeat (2) @(posedge clk);
        #3 arst_ni = 1'b1;

        for (int t = 0; t < 40 && gid.size() < 5; t++) begin
            @(negedge clk);
            if (req_ready_o != 0) begin
                chk("fair_onehot", $onehot(req_ready_o), 1);
                gid.push_back($clog2(req_ready_o));
                gcyc.push_back(cyc);
            end
        end
        chk("fair_cnt", gid.size(), 5);
        foreach (gid[i]) begin
            chk("fair_order", gid[i], i % NR);
            if (i > 0) chk("fair_gap", gcyc[i] - gcyc[i-1], 5);
        end
        @(posedge clk);
        #1 req_valid = '0;

        run_one(1, 1'b1, 5, P);
        stuck1 = 6'b001000;
        run_one(0, 1'b0, 3, P);
        stuck1 = '0;
        run_one(2, 1'b1, 7, 0);
        run_one(3, 1'b0, 6, 0);

        wait_idle();
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        req_set = 4'b0100;
        req_idx[2*IW +: IW] = 3'd1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready_o[2]) got = 1;
        end
        chk("rst_accept", got, 1);
        @(posedge clk);
        #3 arst_ni = 1'b0;
        #1;
        chk("abort_s", s_o, 0);
        chk("abort_r", r_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_rsp", rsp_valid_o, 0);
        req_valid = 4'hF;
        @(posedge clk);
        #3 arst_ni = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", req_ready_o, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();

        stuck1 = NL'($urandom & $urandom);
        stuck0 = NL'($urandom & $urandom) & ~stuck1;
        repeat (10000) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
            req_set = NR'($urandom);
            req_idx = (NR*IW)'($urandom);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_pulse_arbiter.md
SR_PULSE_ARBITER -- requirements
Module: sr_pulse_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4: number of requesters.
- NUM_LATCH, default 8: number of SR latches in the controlled bank.
- PULSE_CYCLES, default 2: width of each s/r pulse in clocks, must be at least 1.
- SETTLE_CYCLES, default 1: quiet clocks after a pulse before sampling, must be at least 1.
- IDX_W, default max(1, clog2(NUM_LATCH)): latch index width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- arst_ni, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, NUM_REQ: per-requester request valid.
- req_set_i, in, NUM_REQ: per-requester operation, 1 = set, 0 = reset.
- req_idx_i, in, NUM_REQ*IDX_W: per-requester target latch index; slice i is bits [i*IDX_W +: IDX_W].
- req_ready_o, out, NUM_REQ: per-requester accept.
- s_o, out, NUM_LATCH: set pulses to the latch bank.
- r_o, out, NUM_LATCH: reset pulses to the latch bank.
- q_i, in, NUM_LATCH: latch q read-back.
- rsp_valid_o, out, 1: completion strobe.
- rsp_id_o, out, clog2(NUM_REQ) (min 1): id of the requester that completed.
- rsp_err_o, out, 1: completion error flag.
- busy_o, out, 1: controller not in IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, PULSE, SETTLE, RESP.

REQ-004 Acceptance in IDLE:
- Round-robin grant over the asserted req_valid_i bits, starting the search at (last granted + 1) mod NUM_REQ.
- req_ready_o SHALL be one-hot and high only for the granted requester.
- req_ready_o SHALL be all-zero outside IDLE or when no valid is asserted.
- req_ready_o MAY depend combinationally on req_valid_i.

REQ-005 A transfer SHALL occur on a clock edge where valid and ready are both high. On that edge the block SHALL capture the requester id, req_set_i and req_idx_i.

REQ-006 After a transfer with an in-range index, the FSM SHALL enter PULSE and stay there exactly PULSE_CYCLES clocks.
- s_o[idx] is high throughout PULSE if set, otherwise r_o[idx] is high.
- All other s_o/r_o bits are low.
- s_o and r_o SHALL be registered outputs.

REQ-007 After PULSE, the FSM SHALL enter SETTLE for exactly SETTLE_CYCLES clocks with all s_o/r_o low. q_i[idx] SHALL be sampled on the final SETTLE edge.

REQ-008 RESP SHALL last exactly one clock, then return to IDLE. During RESP:
- rsp_valid_o = 1.
- rsp_id_o = captured id.
- rsp_err_o = 1 if sampled q_i[idx] differs from the captured set value.

REQ-009 An index of NUM_LATCH or above SHALL be accepted, SHALL skip PULSE and SETTLE, SHALL generate no pulse, and SHALL go directly to RESP with rsp_err_o = 1.

REQ-010 Latency for an in-range request: accept edge, then PULSE_CYCLES + SETTLE_CYCLES clocks, then one RESP clock. The next acceptance is earliest on the edge ending RESP+1 (first IDLE clock). With defaults this is one acceptance per 5 clocks.

REQ-011 Pulse safety invariants:
- Never assert s_o[k] and r_o[k] together.
- Never pulse more than one latch bit at a time.

REQ-012 The round-robin pointer SHALL update only on a transfer. It SHALL move to the granted index, so the next search starts at granted+1.

REQ-013 rsp_valid_o, rsp_id_o and rsp_err_o SHALL be 0 outside RESP.

REQ-014 busy_o SHALL be 1 in PULSE, SETTLE and RESP, and 0 in IDLE.

REQ-015 Changes on req_* inputs outside IDLE SHALL have no effect on an operation in flight.

Reset
REQ-016 When arst_ni = 0, the following SHALL apply asynchronously, without waiting for a clock:
- FSM in IDLE.
- s_o = 0 and r_o = 0.
- rsp_valid_o = 0, rsp_err_o = 0, rsp_id_o = 0.
- busy_o = 0.
- Round-robin pointer set so requester 0 has highest priority.

REQ-017 Reset asserted mid-PULSE SHALL drop the active pulse immediately. No RESP SHALL be generated for the aborted request.

REQ-018 After arst_ni rises, the first transfer SHALL be possible on the first clock edge.

Verification
REQ-019 Set path: defaults; req 1 valid, set=1, idx=5; model q follows the pulse.
- s_o[5] high for exactly 2 clocks, r_o all zero.
- 1 settle clock.
- rsp_valid_o for 1 clock with rsp_id_o=1, rsp_err_o=0.

REQ-020 Mismatch: req 0, set=0, idx=3, with q_i[3] held at 1.
- r_o[3] pulsed for 2 clocks.
- RESP shows rsp_err_o=1.

REQ-021 Fairness: all 4 requesters continuously valid from reset.
- Grant order 0,1,2,3,0.
- Each req_ready_o pulse is one-hot and spaced 5 clocks apart.

REQ-022 Out of range: NUM_LATCH=6, req 2, idx=7.
- Accepted, no s_o/r_o activity.
- RESP the next clock with rsp_err_o=1, rsp_id_o=2.

REQ-023 Reset mid-operation: arst_ni low during the 1st PULSE clock.
- s_o/r_o low before the next edge.
- No rsp_valid_o.
- After release, req 0 is granted first.

REQ-024 Protocol: random valid/idx/set traffic for 10k clocks.
- Assertions hold that s_o&r_o == 0 and popcount(s_o|r_o) <= 1.
- Every transfer yields exactly one RESP.
